fact_accel: RTL

FACT_ACCEL -- requirements
Module: fact_accel

---
 rtl/fact_accel.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fact_accel.sv
`default_nettype none
// ============================================================================
// Module  : fact_accel
// Purpose : Register-mapped iterative factorial engine (n!, truncated result
//           with sticky overflow flag).
// Revision: 1.0 - initial release
// ============================================================================
module fact_accel #(
  parameter int N_WIDTH   = 4,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [1:0]           a,
  input  logic [N_WIDTH-1:0]   wd,
  output logic [OUT_WIDTH-1:0] rd,
  output logic                 busy,
  output logic                 done_pulse
);

  localparam int PW = OUT_WIDTH + N_WIDTH;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic [N_WIDTH-1:0]   cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] result_q, result_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 pulse_q, pulse_d;

  logic                 start_w;
  logic                 nwr_w;
  logic [PW-1:0]        prod_w;

  assign busy       = (state_q == S_MUL);
  assign done_pulse = pulse_q;

  // Busy gating drops both write kinds; the two addresses are mutually exclusive.
  assign start_w = we && (a == 2'b01) && wd[0] && !busy;
  assign nwr_w   = we && (a == 2'b00) && !busy;

  assign prod_w = {{N_WIDTH{1'b0}}, acc_q} * {{OUT_WIDTH{1'b0}}, cnt_q};

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = done_q;
    err_d    = err_q;
    pulse_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          acc_d   = OUT_WIDTH'(1);
          cnt_d   = n_q;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_MUL;
        end else if (nwr_w) begin
          n_d = wd;
        end
      end
      S_MUL: begin
        if (cnt_q > N_WIDTH'(1)) begin
          acc_d = prod_w[OUT_WIDTH-1:0];
          cnt_d = cnt_q - N_WIDTH'(1);
          // Any bit lost by truncation marks overflow; the flag is sticky.
          if (|prod_w[PW-1:OUT_WIDTH]) begin
            err_d = 1'b1;
          end
        end else begin
          result_d = acc_q;
          done_d   = 1'b1;
          pulse_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    rd = '0;
    case (a)
      2'b00:   rd = OUT_WIDTH'(n_q);
      2'b01:   rd = OUT_WIDTH'(busy);
      2'b10:   rd = OUT_WIDTH'({err_q, done_q});
      default: rd = result_q;
    endcase
  end

endmodule
`default_nettype wire
